// File: rtl/writeback_queue.sv
// In-order writeback queue merging ALU and load results into a single register-file write port.
// Optional forwarding lookup (q_hit/q_data) is enabled by defining WBQ_FORWARD_EN.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [2:0]  alu_dst,
  input  logic [23:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [2:0]  mem_dst,
  input  logic [23:0] mem_data,
  output logic        mem_ready,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [23:0] rf_wdata,
  input  logic [2:0]  q_addr,
  output logic        q_hit,
  output logic [23:0] q_data,
  output logic [3:0]  count
);

  localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [2:0]    dst_q  [DEPTH];
  logic [23:0]   data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] alu_wptr;
  logic          mem_push;
  logic          alu_push;
  logic          pop;
  logic [3:0]    count_next;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // alu_ready leaves room for a same-cycle mem push, so both can never overflow
  assign mem_ready = (count < 4'(DEPTH));
  assign alu_ready = (count < 4'(DEPTH - 1));

  assign mem_push = mem_valid && mem_ready && (mem_dst != 3'd0);
  assign alu_push = alu_valid && alu_ready && (alu_dst != 3'd0);
  assign pop      = (count != 4'd0);
  assign alu_wptr = mem_push ? inc(wr_ptr) : wr_ptr;

  assign count_next = count + {3'b000, mem_push} + {3'b000, alu_push} - {3'b000, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
    end else begin
      rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
      wr_ptr <= alu_push ? inc(alu_wptr) : alu_wptr;
      count  <= count_next;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by count alone
  always_ff @(posedge clk) begin
    if (mem_push) begin
      dst_q[wr_ptr]  <= mem_dst;
      data_q[wr_ptr] <= mem_data;
    end
    if (alu_push) begin
      dst_q[alu_wptr]  <= alu_dst;
      data_q[alu_wptr] <= alu_data;
    end
  end

  assign rf_we    = pop;
  assign rf_waddr = pop ? dst_q[rd_ptr]  : 3'd0;
  assign rf_wdata = pop ? data_q[rd_ptr] : 24'd0;

`ifdef WBQ_FORWARD_EN
  // Walk entries oldest to youngest so the last match wins
  always_comb begin
    int idx;
    q_hit  = 1'b0;
    q_data = 24'd0;
    idx    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = int'(rd_ptr) + i;
      if (idx >= DEPTH) idx = idx - DEPTH;
      if ((i < int'(count)) && (q_addr != 3'd0) && (dst_q[idx[PW-1:0]] == q_addr)) begin
        q_hit  = 1'b1;
        q_data = data_q[idx[PW-1:0]];
      end
    end
  end
`else
  logic unused_q_addr;
  assign unused_q_addr = ^q_addr;
  assign q_hit  = 1'b0;
  assign q_data = 24'd0;
`endif

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are 2 to 8.
REQ-002 Port clk SHALL be an input of width 1 and is the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input of width 1, asynchronous and active-high.
REQ-004 Port alu_valid SHALL be an input of width 1; the ALU stage offers a result.
REQ-005 Port alu_dst SHALL be an input of width 3; ALU destination register.
REQ-006 Port alu_data SHALL be an input of width 24; ALU result.
REQ-007 Port alu_ready SHALL be an output of width 1; the queue can accept the ALU result.
REQ-008 Port mem_valid SHALL be an input of width 1; the memory stage offers a load result.
REQ-009 Port mem_dst SHALL be an input of width 3; load destination register.
REQ-010 Port mem_data SHALL be an input of width 24; load data.
REQ-011 Port mem_ready SHALL be an output of width 1; the queue can accept the load result.
REQ-012 Port rf_we SHALL be an output of width 1; register-file write enable.
REQ-013 Port rf_waddr SHALL be an output of width 3; register-file write address.
REQ-014 Port rf_wdata SHALL be an output of width 24; register-file write data.
REQ-015 Port q_addr SHALL be an input of width 3; forwarding lookup register.
REQ-016 Port q_hit SHALL be an output of width 1; a pending write to q_addr exists.
REQ-017 Port q_data SHALL be an output of width 24; the youngest pending data for q_addr.
REQ-018 Port count SHALL be an output of width 4; the number of occupied entries.

Function
REQ-019 The queue SHALL be an in-order FIFO of DEPTH entries, each holding {dst[2:0], data[23:0]}.
REQ-020 Handshakes: a transfer occurs on a rising edge when valid and ready are both high; mem_ready = (count < DEPTH); alu_ready = (count < DEPTH-1); neither ready depends on valid.
REQ-021 On simultaneous mem and ALU transfers, the mem entry SHALL be enqueued first (older), then the ALU entry, in the same cycle.
REQ-022 A transfer with dst == 0 SHALL complete its handshake but SHALL NOT be enqueued, because register 0 is hardwired to zero.
REQ-023 Drain: whenever count != 0, rf_we = 1 and rf_waddr/rf_wdata equal the head entry combinationally, and the head pops on that rising edge; one write per cycle.
REQ-024 Latency: data accepted at edge N into an empty queue SHALL appear on rf_we/rf_waddr/rf_wdata during cycle N+1 and be written at edge N+1.
REQ-025 Push and pop in the same cycle SHALL both take effect; count_next = count + pushes - pop; the read/write pointers wrap modulo DEPTH.
REQ-026 When count == 0, rf_we = 0, rf_waddr = 0, and rf_wdata = 0.
REQ-027 Overflow SHALL be impossible by construction (REQ-020); pop on empty SHALL never occur.

Reset
REQ-028 While rst is high, the pointers and count SHALL be 0, rf_we = 0, alu_ready = mem_ready = 1, and q_hit = 0; entry contents are don't-care.
REQ-029 Reset asserted mid-operation SHALL discard all pending entries immediately, and no partial write SHALL be issued.

Configuration
REQ-030 Macro WBQ_FORWARD_EN SHALL control the forwarding lookup.
REQ-031 With WBQ_FORWARD_EN defined: q_hit = 1 if any occupied entry has dst == q_addr and q_addr != 0, and q_data is the data of the youngest such entry; both are combinational from stored state only (the current cycle's inputs are excluded).
REQ-032 Without WBQ_FORWARD_EN: q_hit = 0 and q_data = 0 constantly, and no compare logic is synthesized.

Verification
REQ-033 Single write: empty queue, alu_valid with dst=3, data=24'h00ABCD -> next cycle rf_we=1, rf_waddr=3, rf_wdata=24'h00ABCD; count=1, then 0.
REQ-034 Dual push: mem(dst=1, 24'h000011) and alu(dst=1, 24'h000022) in the same cycle -> writes in order 24'h000011 then 24'h000022; with forwarding, q_addr=1 before the drain gives q_hit=1, q_data=24'h000022.
REQ-035 Register zero: alu_valid with dst=0 -> handshake completes, count stays 0, rf_we stays 0.
REQ-036 Full: DEPTH=4, pushing while rf drains each cycle -> mem_ready falls at count=4 and alu_ready falls at count>=3; no entry is lost or duplicated across pointer wrap (check 16 sequential values).
REQ-037 Reset mid-stream: assert rst with count=3 -> rf_we=0 and count=0 immediately; after release, the queue accepts a new entry normally.
REQ-038 Macro off: build without WBQ_FORWARD_EN, run REQ-034 -> q_hit=0 and q_data=0 throughout.
